// File: rtl/instr_decode_stage_pkg.sv
// Shared decode types: op classes, immediate formats, RV32I opcodes and the output-register layout.
// Pure declarations; no state, no latency, no handshake.
package decode_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OC_LUI,
    OC_AUIPC,
    OC_JAL,
    OC_JALR,
    OC_BRANCH,
    OC_LOAD,
    OC_STORE,
    OC_OP_IMM,
    OC_OP,
    OC_SYSTEM,
    OC_ILLEGAL
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // claim marks that this entry owns a scoreboard bit for rd
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    op_class_e       op_class;
    logic            br_pred;
    logic            illegal;
    logic            claim;
  } decoded_t;

  function automatic op_class_e opcode_class(input logic [6:0] opc);
    op_class_e cls;
    case (opc)
      OPC_LUI:    cls = OC_LUI;
      OPC_AUIPC:  cls = OC_AUIPC;
      OPC_JAL:    cls = OC_JAL;
      OPC_JALR:   cls = OC_JALR;
      OPC_BRANCH: cls = OC_BRANCH;
      OPC_LOAD:   cls = OC_LOAD;
      OPC_STORE:  cls = OC_STORE;
      OPC_OP_IMM: cls = OC_OP_IMM;
      OPC_OP:     cls = OC_OP;
      OPC_SYSTEM: cls = OC_SYSTEM;
      default:    cls = OC_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Decode-stage signal bundle: fetch word + ack, regfile read port, write-back, execute valid/ack.
// Master is the surrounding pipeline, slave is the decode stage itself.
interface instr_decode_stage_if;

  logic                  flush_i;
  logic                  valid_i;
  logic [31:0]           instr_i;
  logic [31:0]           pc_i;
  logic                  br_pred_i;
  logic                  ack_o;
  logic [4:0]            rs1_addr_o;
  logic [4:0]            rs2_addr_o;
  logic [31:0]           rs1_data_i;
  logic [31:0]           rs2_data_i;
  logic                  wb_valid_i;
  logic [4:0]            wb_rd_i;
  logic                  valid_o;
  logic                  ack_i;
  logic [31:0]           pc_o;
  logic [31:0]           rs1_data_o;
  logic [31:0]           rs2_data_o;
  logic [31:0]           imm_o;
  logic [4:0]            rd_o;
  logic [2:0]            funct3_o;
  logic                  funct7b5_o;
  decode_pkg::op_class_e op_class_o;
  logic                  br_pred_o;
  logic                  illegal_o;
  logic [31:0]           dbg_busy_o;

  modport master (
    output flush_i, valid_i, instr_i, pc_i, br_pred_i,
    output rs1_data_i, rs2_data_i, wb_valid_i, wb_rd_i, ack_i,
    input  ack_o, rs1_addr_o, rs2_addr_o, valid_o,
    input  pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o,
    input  funct3_o, funct7b5_o, op_class_o, br_pred_o, illegal_o, dbg_busy_o
  );

  modport slave (
    input  flush_i, valid_i, instr_i, pc_i, br_pred_i,
    input  rs1_data_i, rs2_data_i, wb_valid_i, wb_rd_i, ack_i,
    output ack_o, rs1_addr_o, rs2_addr_o, valid_o,
    output pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o,
    output funct3_o, funct7b5_o, op_class_o, br_pred_o, illegal_o, dbg_busy_o
  );

endinterface

// File: rtl/instr_decode_stage_imm_decoder.sv
// Combinational RV32I immediate extraction; picks the format from the opcode and sign-extends.
// Zero latency, no handshake; formats without an immediate yield 0.
module imm_decoder
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output imm_type_e   imm_type
);

  always_comb begin
    imm_type = IMM_NONE;
    case (instr[6:0])
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: imm_type = IMM_I;
      OPC_STORE:                                  imm_type = IMM_S;
      OPC_BRANCH:                                 imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:                         imm_type = IMM_U;
      OPC_JAL:                                    imm_type = IMM_J;
      default:                                    imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: 1-cycle capture into one output register, RAW stall via a 32-entry busy scoreboard.
// Accepts only when the output register is free or being acked and no source is busy; flush kills the held word.
module instr_decode_stage
  import decode_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_i,
  instr_decode_stage_if.slave  bus
);

  logic [6:0]  opc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  imm_type_e   imm_type;
  op_class_e   op_class;
  logic        illegal;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        writes_rd;

  assign opc = bus.instr_i[6:0];
  assign rs1 = bus.instr_i[19:15];
  assign rs2 = bus.instr_i[24:20];
  assign rd  = bus.instr_i[11:7];

  imm_decoder u_imm_decoder (
    .instr    (bus.instr_i),
    .imm      (imm),
    .imm_type (imm_type)
  );

  // OP is the only legal opcode without an immediate format
  always_comb begin
    illegal   = (imm_type == IMM_NONE) && (opc != OPC_OP);
    op_class  = illegal ? OC_ILLEGAL : opcode_class(opc);
    uses_rs1  = !(op_class inside {OC_LUI, OC_AUIPC, OC_JAL});
    uses_rs2  = op_class inside {OC_BRANCH, OC_STORE, OC_OP};
    writes_rd = (op_class inside {OC_LUI, OC_AUIPC, OC_JAL, OC_JALR,
                                  OC_LOAD, OC_OP_IMM, OC_OP}) && (rd != 5'd0);
  end

  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic        out_vld_q;
  decoded_t    out_q;
  decoded_t    out_d;
  logic        hazard;
  logic        can_take;
  logic        capture;

  assign hazard   = (uses_rs1 & busy_q[rs1]) | (uses_rs2 & busy_q[rs2]);
  assign can_take = !out_vld_q | bus.ack_i;
  assign capture  = bus.valid_i & can_take & !hazard & !bus.flush_i & !rst_i;

  always_comb begin
    out_d          = out_q;
    out_d.pc       = bus.pc_i;
    out_d.rs1_data = bus.rs1_data_i;
    out_d.rs2_data = bus.rs2_data_i;
    out_d.imm      = imm;
    out_d.rd       = rd;
    out_d.funct3   = bus.instr_i[14:12];
    out_d.funct7b5 = bus.instr_i[30];
    out_d.op_class = op_class;
    out_d.br_pred  = bus.br_pred_i;
    out_d.illegal  = illegal;
    out_d.claim    = writes_rd;
  end

  // Write order matters: a capture claiming the index being retired this cycle must stay busy
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid_i)
      busy_d[bus.wb_rd_i] = 1'b0;
    if (bus.flush_i && out_vld_q && out_q.claim)
      busy_d[out_q.rd] = 1'b0;
    if (capture && writes_rd)
      busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (bus.flush_i) begin
      out_vld_q   <= 1'b0;
      out_q.claim <= 1'b0;
    end else if (capture) begin
      out_vld_q <= 1'b1;
      out_q     <= out_d;
    end else if (bus.ack_i) begin
      out_vld_q <= 1'b0;
    end
  end

  assign bus.ack_o      = capture;
  assign bus.rs1_addr_o = rs1;
  assign bus.rs2_addr_o = rs2;
  assign bus.valid_o    = out_vld_q;
  assign bus.pc_o       = out_q.pc;
  assign bus.rs1_data_o = out_q.rs1_data;
  assign bus.rs2_data_o = out_q.rs2_data;
  assign bus.imm_o      = out_q.imm;
  assign bus.rd_o       = out_q.rd;
  assign bus.funct3_o   = out_q.funct3;
  assign bus.funct7b5_o = out_q.funct7b5;
  assign bus.op_class_o = out_q.op_class;
  assign bus.br_pred_o  = out_q.br_pred;
  assign bus.illegal_o  = out_q.illegal;
  assign bus.dbg_busy_o = busy_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: a reference model of the decode/scoreboard rules checked
// every cycle, plus literal expectations at key points of the stimulus.
module tb_instr_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_decode_stage_if dif ();

  instr_decode_stage dut (
    .clk   (clk),
    .rst_i (rst),
    .bus   (dif.slave)
  );

  // regfile stub: data is a recognisable tag of the address
  assign dif.rs1_data_i = 32'hA000_0000 | {27'd0, dif.rs1_addr_o};
  assign dif.rs2_data_i = 32'hB000_0000 | {27'd0, dif.rs2_addr_o};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_decode(input logic [31:0] ins, output op_class_e cls,
                                     output logic [31:0] imm, output bit u1, output bit u2,
                                     output bit wr);
    logic [31:0] i_imm;
    i_imm = {{20{ins[31]}}, ins[31:20]};
    case (ins[6:0])
      7'h37: begin cls = OC_LUI;    imm = {ins[31:12], 12'h000}; end
      7'h17: begin cls = OC_AUIPC;  imm = {ins[31:12], 12'h000}; end
      7'h6F: begin cls = OC_JAL;    imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'h67: begin cls = OC_JALR;   imm = i_imm; end
      7'h63: begin cls = OC_BRANCH; imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'h03: begin cls = OC_LOAD;   imm = i_imm; end
      7'h23: begin cls = OC_STORE;  imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'h13: begin cls = OC_OP_IMM; imm = i_imm; end
      7'h33: begin cls = OC_OP;     imm = 32'd0; end
      7'h73: begin cls = OC_SYSTEM; imm = i_imm; end
      default: begin cls = OC_ILLEGAL; imm = 32'd0; end
    endcase
    u1 = !(cls inside {OC_LUI, OC_AUIPC, OC_JAL});
    u2 = cls inside {OC_BRANCH, OC_STORE, OC_OP};
    wr = (cls inside {OC_LUI, OC_AUIPC, OC_JAL, OC_JALR, OC_LOAD, OC_OP_IMM, OC_OP})
         && (ins[11:7] != 5'd0);
  endfunction

  bit          m_busy [32];
  bit          m_valid;
  bit          m_claim;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  bit          m_f7, m_bp, m_ill;
  op_class_e   m_cls;

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit m_capture();
    op_class_e c;
    logic [31:0] im;
    bit u1, u2, wr, hz;
    ref_decode(dif.instr_i, c, im, u1, u2, wr);
    hz = (u1 && m_busy[dif.instr_i[19:15]]) || (u2 && m_busy[dif.instr_i[24:20]]);
    return dif.valid_i && (!m_valid || dif.ack_i) && !hz && !dif.flush_i && !rst;
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    op_class_e c;
    logic [31:0] im;
    bit u1, u2, wr, cap;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_valid = 0; m_claim = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
      m_rd = 0; m_f3 = 0; m_f7 = 0; m_bp = 0; m_ill = 0; m_cls = OC_LUI;
    end else begin
      cap = m_capture();
      ref_decode(dif.instr_i, c, im, u1, u2, wr);
      if (dif.wb_valid_i) m_busy[dif.wb_rd_i] = 1'b0;
      if (dif.flush_i && m_valid && m_claim) m_busy[m_rd] = 1'b0;
      if (dif.flush_i) begin
        m_valid = 0;
        m_claim = 0;
      end else if (cap) begin
        m_valid = 1;
        m_pc    = dif.pc_i;
        m_rs1d  = 32'hA000_0000 | {27'd0, dif.instr_i[19:15]};
        m_rs2d  = 32'hB000_0000 | {27'd0, dif.instr_i[24:20]};
        m_imm   = im;
        m_rd    = dif.instr_i[11:7];
        m_f3    = dif.instr_i[14:12];
        m_f7    = dif.instr_i[30];
        m_cls   = c;
        m_bp    = dif.br_pred_i;
        m_ill   = (c == OC_ILLEGAL);
        m_claim = wr;
        if (wr) m_busy[dif.instr_i[11:7]] = 1'b1;
      end else if (dif.ack_i) begin
        m_valid = 0;
      end
      m_busy[0] = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cmp_valid", 32'(dif.valid_o), 32'(m_valid));
    chk("cmp_ack", 32'(dif.ack_o), 32'(m_capture()));
    chk("cmp_busy", dif.dbg_busy_o, busy_vec());
    chk("cmp_pc", dif.pc_o, m_pc);
    chk("cmp_rs1", dif.rs1_data_o, m_rs1d);
    chk("cmp_rs2", dif.rs2_data_o, m_rs2d);
    chk("cmp_imm", dif.imm_o, m_imm);
    chk("cmp_rd", 32'(dif.rd_o), 32'(m_rd));
    chk("cmp_f3", 32'(dif.funct3_o), 32'(m_f3));
    chk("cmp_f7", 32'(dif.funct7b5_o), 32'(m_f7));
    chk("cmp_cls", 32'(dif.op_class_o), 32'(m_cls));
    chk("cmp_bp", 32'(dif.br_pred_o), 32'(m_bp));
    chk("cmp_ill", 32'(dif.illegal_o), 32'(m_ill));
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
    dif.valid_i = 1'b1;
    dif.instr_i = ins;
    dif.pc_i    = pc;
  endtask

  logic [31:0] tput [5];

  initial begin
    rst = 1'b1;
    dif.flush_i = 0; dif.valid_i = 0; dif.instr_i = 0; dif.pc_i = 0; dif.br_pred_i = 0;
    dif.wb_valid_i = 0; dif.wb_rd_i = 0; dif.ack_i = 0;
    tput[0] = 32'h0041A583; tput[1] = 32'h00001617; tput[2] = 32'hFFC086E7;
    tput[3] = 32'h00000073; tput[4] = 32'h40310733;

    fetch(32'h00700293, 32'h100);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(dif.valid_o), 32'd0);
    chk("rst_ack", 32'(dif.ack_o), 32'd0);
    chk("rst_busy", dif.dbg_busy_o, 32'd0);
    chk("rst_pc", dif.pc_o, 32'd0);

    nxt(); rst = 1'b0; dif.ack_i = 1'b1; #1;
    chk("addi_ack", 32'(dif.ack_o), 32'd1);

    nxt(); fetch(32'h00528333, 32'h104); #1;
    chk("addi_valid", 32'(dif.valid_o), 32'd1);
    chk("addi_pc", dif.pc_o, 32'h100);
    chk("addi_imm", dif.imm_o, 32'd7);
    chk("addi_rd", 32'(dif.rd_o), 32'd5);
    chk("addi_cls", 32'(dif.op_class_o), 32'(OC_OP_IMM));
    chk("addi_busy", dif.dbg_busy_o, 32'h0000_0020);
    chk("raw_stall", 32'(dif.ack_o), 32'd0);

    nxt(); dif.wb_valid_i = 1'b1; dif.wb_rd_i = 5'd5; #1;
    chk("drain_valid", 32'(dif.valid_o), 32'd0);
    chk("no_bypass", 32'(dif.ack_o), 32'd0);

    nxt(); dif.wb_valid_i = 1'b0; #1;
    chk("wb_clear", dif.dbg_busy_o, 32'd0);
    chk("add_ack", 32'(dif.ack_o), 32'd1);

    nxt(); fetch(32'hFE000CE3, 32'h108); dif.br_pred_i = 1'b1;
    dif.wb_valid_i = 1'b1; dif.wb_rd_i = 5'd6; #1;
    chk("add_rs1", dif.rs1_data_o, 32'hA000_0005);
    chk("add_rd", 32'(dif.rd_o), 32'd6);
    chk("add_busy", dif.dbg_busy_o, 32'h0000_0040);
    chk("beq_ack", 32'(dif.ack_o), 32'd1);

    nxt(); dif.wb_valid_i = 1'b0; dif.br_pred_i = 1'b0; dif.ack_i = 1'b0;
    fetch(32'h00100393, 32'h10C); #1;
    chk("beq_imm", dif.imm_o, 32'hFFFF_FFF8);
    chk("beq_cls", 32'(dif.op_class_o), 32'(OC_BRANCH));
    chk("beq_bp", 32'(dif.br_pred_o), 32'd1);
    chk("beq_busy", dif.dbg_busy_o, 32'd0);
    chk("hold_ack", 32'(dif.ack_o), 32'd0);

    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      chk("hold_valid", 32'(dif.valid_o), 32'd1);
      chk("hold_pc", dif.pc_o, 32'h108);
      chk("hold_ack", 32'(dif.ack_o), 32'd0);
    end

    dif.ack_i = 1'b1; #1;
    chk("release_ack", 32'(dif.ack_o), 32'd1);

    nxt(); dif.ack_i = 1'b0; dif.flush_i = 1'b1; fetch(32'h123454B7, 32'h110); #1;
    chk("x7_rd", 32'(dif.rd_o), 32'd7);
    chk("x7_busy", dif.dbg_busy_o, 32'h0000_0080);
    chk("flush_blocks", 32'(dif.ack_o), 32'd0);

    nxt(); dif.flush_i = 1'b0; dif.ack_i = 1'b1; fetch(32'h0000047F, 32'h114); #1;
    chk("flush_kill", 32'(dif.valid_o), 32'd0);
    chk("flush_release", dif.dbg_busy_o, 32'd0);
    chk("ill_ack", 32'(dif.ack_o), 32'd1);

    nxt(); fetch(32'h123454B7, 32'h118); #1;
    chk("ill_flag", 32'(dif.illegal_o), 32'd1);
    chk("ill_cls", 32'(dif.op_class_o), 32'(OC_ILLEGAL));
    chk("ill_busy", dif.dbg_busy_o, 32'd0);

    nxt(); fetch(32'h010000EF, 32'h11C); #1;
    chk("lui_imm", dif.imm_o, 32'h1234_5000);
    chk("lui_busy", dif.dbg_busy_o, 32'h0000_0200);

    nxt(); fetch(32'h00300513, 32'h120); #1;
    chk("jal_imm", dif.imm_o, 32'h0000_0010);
    chk("jal_busy", dif.dbg_busy_o, 32'h0000_0202);
    rst = 1'b1; dif.wb_valid_i = 1'b1; dif.wb_rd_i = 5'd9; #1;
    chk("midrst_valid", 32'(dif.valid_o), 32'd0);
    chk("midrst_pc", dif.pc_o, 32'd0);
    chk("midrst_imm", dif.imm_o, 32'd0);
    chk("midrst_busy", dif.dbg_busy_o, 32'd0);
    chk("midrst_ack", 32'(dif.ack_o), 32'd0);

    nxt(); rst = 1'b0; dif.wb_rd_i = 5'd10; #1;
    chk("postrst_busy", dif.dbg_busy_o, 32'd0);
    chk("postrst_ack", 32'(dif.ack_o), 32'd1);

    nxt(); dif.wb_valid_i = 1'b0; fetch(32'h00A12423, 32'h124); #1;
    chk("set_wins", dif.dbg_busy_o, 32'h0000_0400);
    chk("sw_stall", 32'(dif.ack_o), 32'd0);

    nxt(); dif.wb_valid_i = 1'b1; dif.wb_rd_i = 5'd10;
    nxt(); dif.wb_valid_i = 1'b0; #1;
    chk("sw_ack", 32'(dif.ack_o), 32'd1);

    for (int i = 0; i < 5; i++) begin
      nxt(); fetch(tput[i], 32'h200 + 32'(i * 4)); #1;
      chk("tput_ack", 32'(dif.ack_o), 32'd1);
    end
    nxt(); dif.valid_i = 1'b0;
    repeat (3) nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
